// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM states, frame layout constants and frame-width helper for the SPI register peripheral
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } state_t;

   // R/W is the first bit on the wire, so it lands in the shift register MSB
   localparam int RW_BIT = 0;

   function automatic int frame_w(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/spi_reg_peripheral_sync_edge.sv
// spi_sync_edge: multi-stage input synchroniser with one-clk rise/fall pulses on the synchronised level
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   // shift the async input through the chain and remember the previous synced level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], d};
         prev <= sync[SYNC_STAGES-1];
      end
   end

   assign q    = sync[SYNC_STAGES-1];
   assign rise = q & ~prev;
   assign fall = ~q & prev;

endmodule

// File: rtl/spi_reg_peripheral.sv
// spi_reg_peripheral: clk-domain SPI mode-0 write-register bank; define SPI_READBACK_EN to add the cipo readback port
module spi_reg_peripheral
   import spi_pkg::*;
#(
   parameter int NUM_REGS    = 5,
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 7,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cs_n,
   input  logic                       sclk,
   input  logic                       copi,
   output logic [NUM_REGS*DATA_W-1:0] regs,
   output logic                       wr_valid,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic                       frame_err
`ifdef SPI_READBACK_EN
   ,
   output logic                       cipo
`endif
);

   localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
   localparam int CNT_W   = $clog2(FRAME_W + 2);
   localparam int RW_IDX  = FRAME_W - 1 - RW_BIT;
`ifdef SPI_READBACK_EN
   localparam bit RB_EN = 1'b1;
`else
   localparam bit RB_EN = 1'b0;
`endif

   logic               sclk_rise, sclk_fall, cs_rise, cs_fall, copi_s;
   logic               unused_sclk_q, unused_cs_q, unused_copi_r, unused_copi_f;
   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [FRAME_W-1:0] sr;
   logic [DATA_W-1:0]  bank [NUM_REGS];
   logic               f_rw, len_ok, addr_ok, frame_ok, commit, discard;
   logic [ADDR_W-1:0]  f_addr;
   logic [DATA_W-1:0]  f_data;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
      .clk(clk), .rst_n(rst_n), .d(sclk), .q(unused_sclk_q), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
      .clk(clk), .rst_n(rst_n), .d(cs_n), .q(unused_cs_q), .rise(cs_rise), .fall(cs_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_copi (
      .clk(clk), .rst_n(rst_n), .d(copi), .q(copi_s), .rise(unused_copi_r), .fall(unused_copi_f)
   );

   assign f_rw     = sr[RW_IDX];
   assign f_addr   = sr[FRAME_W-2 -: ADDR_W];
   assign f_data   = sr[DATA_W-1:0];
   assign len_ok   = cnt == CNT_W'(FRAME_W);
   assign addr_ok  = {1'b0, f_addr} < (ADDR_W+1)'(NUM_REGS);
   assign frame_ok = len_ok && addr_ok;
   assign commit   = state == CHECK && frame_ok && f_rw;
   assign discard  = state == CHECK && !(frame_ok && (f_rw || RB_EN));

   // frame FSM: a cs_n fall (re)starts a frame, sclk rises shift bits in, cs_n rise ends it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         sr    <= '0;
      end else begin
         case (state)
            IDLE: if (cs_fall) begin
               cnt   <= '0;
               sr    <= '0;
               state <= SHIFT;
            end
            SHIFT: if (cs_fall) begin
               cnt <= '0;
               sr  <= '0;
            end else begin
               if (sclk_rise) begin
                  sr  <= {sr[FRAME_W-2:0], copi_s};
                  cnt <= (cnt == CNT_W'(FRAME_W + 1)) ? cnt : cnt + CNT_W'(1);
               end
               if (cs_rise) state <= CHECK;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // commit or discard the checked frame; registers only change on a good write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_valid  <= 1'b0;
         frame_err <= 1'b0;
         wr_addr   <= '0;
         for (int k = 0; k < NUM_REGS; k++) bank[k] <= '0;
      end else begin
         wr_valid  <= commit;
         frame_err <= discard;
         if (commit) wr_addr <= f_addr;
         for (int k = 0; k < NUM_REGS; k++)
            if (commit && f_addr == ADDR_W'(k)) bank[k] <= f_data;
      end
   end

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
      assign regs[k*DATA_W +: DATA_W] = bank[k];
   end

`ifdef SPI_READBACK_EN
   logic [DATA_W-1:0] rd_sr, rd_word;
   logic              rd_act;

   // register selected by the address bits just shifted in (low bits of sr before data arrives)
   always_comb begin
      rd_word = '0;
      for (int k = 0; k < NUM_REGS; k++)
         if (sr[ADDR_W-1:0] == ADDR_W'(k)) rd_word = bank[k];
   end

   // on sclk falls: load the word after the last address bit, then shift it out MSB first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_act <= 1'b0;
         rd_sr  <= '0;
      end else if (state != SHIFT || cs_fall) begin
         rd_act <= 1'b0;
      end else if (sclk_fall) begin
         if (cnt == CNT_W'(1 + ADDR_W)) begin
            rd_act <= !sr[ADDR_W] && ({1'b0, sr[ADDR_W-1:0]} < (ADDR_W+1)'(NUM_REGS));
            rd_sr  <= rd_word;
         end else begin
            rd_sr <= rd_sr << 1;
            if (cnt >= CNT_W'(FRAME_W)) rd_act <= 1'b0;
         end
      end
   end

   assign cipo = rd_act & rd_sr[DATA_W-1];
`else
   logic unused_sclk_fall;
   assign unused_sclk_fall = sclk_fall;
`endif

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// tb_spi_reg_peripheral: table-driven and randomized SPI frames checked against a register-bank model
module tb_spi_reg_peripheral;

   localparam int NUM_REGS = 5;
   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 7;
   localparam int SYNC     = 2;
   localparam int HALF     = 5;
   localparam int LAT      = SYNC + 2;
`ifdef SPI_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic                       clk = 1'b0, rst_n = 1'b0, cs_n = 1'b1, sclk = 1'b0, copi = 1'b0;
   logic [NUM_REGS*DATA_W-1:0] regs;
   logic                       wr_valid, frame_err;
   logic [ADDR_W-1:0]          wr_addr;
`ifdef SPI_READBACK_EN
   logic                       cipo;
`endif

   spi_reg_peripheral #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sclk(sclk), .copi(copi),
      .regs(regs), .wr_valid(wr_valid), .wr_addr(wr_addr), .frame_err(frame_err)
`ifdef SPI_READBACK_EN
      , .cipo(cipo)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rw;
      logic [6:0] a;
      logic [7:0] d;
      int         n;
      int         ev;
      int         ee;
   } vec_t;

   int         vectors = 0, miscompares = 0;
   int         nv = 0, ne = 0, lat;
   logic [6:0] last_addr = '0;
   logic [7:0] rd_bits;
   logic [7:0] mdl [NUM_REGS];
   vec_t       tbl [10];

   always @(negedge clk) begin
      if (wr_valid) begin
         nv++;
         last_addr = wr_addr;
      end
      if (frame_err) ne++;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [NUM_REGS*DATA_W-1:0] flat();
      logic [NUM_REGS*DATA_W-1:0] r;
      for (int k = 0; k < NUM_REGS; k++) r[k*DATA_W +: DATA_W] = mdl[k];
      return r;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d, input int n, input int abort_at);
      logic [15:0] f;
      logic [31:0] ext;
      f = {rw, a, d};
      ext = $urandom;
      lat = 0;
      rd_bits = '0;
      cs_n = 1'b0;
      tick(HALF);
      for (int i = 0; i < n; i++) begin
         if (i == abort_at) begin
            rst_n = 1'b0;
            tick(2);
            chk("async_reset_regs", regs, '0);
            sclk = 1'b0;
            cs_n = 1'b1;
            copi = 1'b0;
            tick(2);
            rst_n = 1'b1;
            tick(10);
            return;
         end
         copi = (i < 16) ? f[15-i] : ext[i-16];
         tick(HALF);
`ifdef SPI_READBACK_EN
         if (i >= 8 && i < 16) rd_bits = {rd_bits[6:0], cipo};
`endif
         sclk = 1'b1;
         tick(HALF);
         sclk = 1'b0;
      end
      tick(HALF);
      copi = 1'b0;
      cs_n = 1'b1;
      for (int k = 1; k <= 12 && lat == 0; k++) begin
         tick(1);
         if (wr_valid || frame_err) lat = k;
      end
      tick(10);
   endtask

   task automatic run(input logic rw, input logic [6:0] a, input logic [7:0] d, input int n, input int ev, input int ee);
      int pv, pe;
      pv = nv;
      pe = ne;
      send(rw, a, d, n, -1);
      if (n == 16 && rw && a < NUM_REGS) mdl[a] = d;
      chk("wr_valid_pulses", nv - pv, ev);
      chk("frame_err_pulses", ne - pe, ee);
      chk("pulse_latency", lat, (ev || ee) ? LAT : 0);
      chk("regs", regs, flat());
      if (ev != 0) chk("wr_addr", last_addr, a);
      if (RB && !rw && n == 16 && a < NUM_REGS) chk("cipo_data", rd_bits, mdl[a]);
   endtask

   initial begin
      int pv, pe;
      for (int k = 0; k < NUM_REGS; k++) mdl[k] = '0;
      tbl[0] = '{1'b1, 7'h02, 8'hA5, 16, 1, 0};
      tbl[1] = '{1'b1, 7'h00, 8'h11, 16, 1, 0};
      tbl[2] = '{1'b1, 7'h04, 8'hFF, 16, 1, 0};
      tbl[3] = '{1'b1, 7'h05, 8'h33, 16, 0, 1};
      tbl[4] = '{1'b1, 7'h01, 8'h77, 15, 0, 1};
      tbl[5] = '{1'b1, 7'h01, 8'h77, 17, 0, 1};
      tbl[6] = '{1'b1, 7'h01, 8'h5A, 16, 1, 0};
      tbl[7] = '{1'b0, 7'h01, 8'h00, 16, 0, RB ? 0 : 1};
      tbl[8] = '{1'b1, 7'h7F, 8'h12, 16, 0, 1};
      tbl[9] = '{1'b0, 7'h01, 8'h00, 12, 0, 1};

      tick(3);
      chk("reset_regs", regs, '0);
      chk("reset_wr_valid", wr_valid, 1'b0);
      chk("reset_frame_err", frame_err, 1'b0);
      chk("reset_wr_addr", wr_addr, '0);
      rst_n = 1'b1;
      tick(3);

      for (int t = 0; t < 10; t++) run(tbl[t].rw, tbl[t].a, tbl[t].d, tbl[t].n, tbl[t].ev, tbl[t].ee);

      pv = nv;
      pe = ne;
      send(1'b1, 7'h03, 8'h3C, 16, 8);
      for (int k = 0; k < NUM_REGS; k++) mdl[k] = '0;
      chk("midframe_reset_regs", regs, flat());
      chk("midframe_reset_wr_valid", nv - pv, 0);
      chk("midframe_reset_frame_err", ne - pe, 0);
      run(1'b1, 7'h03, 8'h3C, 16, 1, 0);

      for (int r = 0; r < 40; r++) begin
         logic       rw;
         logic [6:0] a;
         logic [7:0] d;
         int         sel, n, ok;
         rw  = 1'($urandom_range(0, 1));
         a   = 7'($urandom_range(0, 7));
         d   = 8'($urandom);
         sel = $urandom_range(0, 5);
         n   = (sel == 0) ? 15 : (sel == 1) ? 17 : (sel == 2) ? $urandom_range(1, 14) : 16;
         ok  = (n == 16 && a < NUM_REGS) ? 1 : 0;
         run(rw, a, d, n, (ok != 0 && rw) ? 1 : 0, (ok != 0 && (rw || RB)) ? 0 : 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
